// File: rtl/fp_add_pkg.sv
// Purpose: shared field positions, exponent limits, states and idle flags for the FP adder stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Consumers: normalise_sum and PackAdder. No ports.
package fp_add_pkg;

  // Extended mantissa layout: [27] carry-out, [26] hidden, [25:3] fraction, [2:0] G/R/S.
  localparam int SUM_CARRY  = 27;
  localparam int SUM_HIDDEN = 26;

  // Unbiased signed exponent field inside the 32-bit sout word.
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;

  localparam int EXP_MIN_DFLT = -126;  // denormal floor
  localparam int EXP_MAX_DFLT = 127;   // largest finite exponent

  // Tells PackAdder whether to pass sout through untouched.
  localparam logic put_idle = 1'b1;
  localparam logic no_idle  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_HOLD = 2'd2
  } norm_state_e;

endpackage

// File: rtl/normalise_lzc.sv
// Purpose: 27-bit combinational leading-zero counter for single-cycle normalisation.
// Latency: combinational.
// Backpressure: none.
// Ports: value[26:0] in; count[4:0] out = leading zeros of value (27 when value is 0).
// Only built when NORMALISE_LZC_EN is defined; the default build has no use for it.
`ifdef NORMALISE_LZC_EN
module normalise_lzc (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

endmodule
`endif

// File: rtl/normalise_sum.sv
// Purpose: normalises the unpacked adder sum (hidden bit to [26], or exponent down to the floor) for PackAdder.
// Latency: bypass 1 edge; otherwise 2 edges, plus k edges for a k-bit left shift unless NORMALISE_LZC_EN (fixed 2).
// Backpressure: one word in flight; in_ready only in S_IDLE, result held stable in S_HOLD until out_ready.
// Ports: clock, reset_n (async, active low); in_valid/in_ready + idle_AddSum, sout_AddSum[31:0], sum_AddSum[27:0];
//        out_valid/out_ready + idle_NormaliseSum, sout_NormaliseSum[31:0], sum_NormaliseSum[27:0].
// Config macro: NORMALISE_LZC_EN selects the single-cycle leading-zero shift over the bit-serial loop.
module normalise_sum
  import fp_add_pkg::*;
#(
  parameter int EXP_MIN = EXP_MIN_DFLT,
  parameter int EXP_MAX = EXP_MAX_DFLT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        idle_AddSum,
  input  logic [31:0] sout_AddSum,
  input  logic [27:0] sum_AddSum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        idle_NormaliseSum,
  output logic [31:0] sout_NormaliseSum,
  output logic [27:0] sum_NormaliseSum
);

  localparam logic signed [9:0] EXP_MIN_W = 10'(EXP_MIN);
  localparam logic signed [9:0] EXP_MAX_W = 10'(EXP_MAX);

  norm_state_e       state_q, state_d;
  logic signed [9:0] exp_q, exp_d;     // 10 bits so exponent +1 past 127 is still visible
  logic [27:0]       sum_q, sum_d;
  logic [31:0]       sout_q, sout_d;
  logic              idle_q, idle_d;

`ifdef NORMALISE_LZC_EN
  logic [4:0] lz;
  logic [9:0] room;
  logic [9:0] shamt;

  normalise_lzc u_lzc (
    .value (sum_q[SUM_HIDDEN:0]),
    .count (lz)
  );

  // Only consulted in S_NORM rule 4, where exp_q > EXP_MIN so room is positive.
  assign room  = 10'(exp_q - EXP_MIN_W);
  assign shamt = ({5'b0, lz} < room) ? {5'b0, lz} : room;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      sum_q   <= '0;
      sout_q  <= '0;
      idle_q  <= no_idle;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      sum_q   <= sum_d;
      sout_q  <= sout_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    sum_d   = sum_q;
    sout_d  = sout_q;
    idle_d  = idle_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          sum_d = sum_AddSum;
          exp_d = {{2{sout_AddSum[EXP_HI]}}, sout_AddSum[EXP_HI:EXP_LO]};
          if (idle_AddSum) begin
            sout_d  = sout_AddSum;
            idle_d  = put_idle;
            state_d = S_HOLD;
          end else begin
            sout_d  = {sout_AddSum[31], sout_AddSum[EXP_HI:EXP_LO], 23'b0};
            idle_d  = no_idle;
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (sum_q[SUM_CARRY]) begin
          // Right shift folds the dropped bit into sticky.
          sum_d   = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
          exp_d   = exp_q + 10'sd1;
          state_d = S_HOLD;
          if (exp_d > EXP_MAX_W) begin
            // Overflow: hand PackAdder a ready-made infinity.
            sout_d = {sout_q[31], 8'hFF, 23'b0};
            idle_d = put_idle;
          end else begin
            sout_d = {sout_q[31], exp_d[7:0], 23'b0};
          end
        end else if (sum_q == '0) begin
          exp_d   = EXP_MIN_W;
          sout_d  = {sout_q[31], exp_d[7:0], 23'b0};
          state_d = S_HOLD;
        end else if (sum_q[SUM_HIDDEN] || (exp_q <= EXP_MIN_W)) begin
          state_d = S_HOLD;
        end else begin
`ifdef NORMALISE_LZC_EN
          sum_d   = sum_q << shamt;
          exp_d   = exp_q - $signed(shamt);
          state_d = S_HOLD;
`else
          sum_d   = {sum_q[26:0], 1'b0};
          exp_d   = exp_q - 10'sd1;
`endif
          sout_d  = {sout_q[31], exp_d[7:0], 23'b0};
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready          = (state_q == S_IDLE);
  assign out_valid         = (state_q == S_HOLD);
  assign idle_NormaliseSum = idle_q;
  assign sout_NormaliseSum = sout_q;
  assign sum_NormaliseSum  = sum_q;

endmodule
